// File: rtl/life_gen_scheduler.sv
// Generation sequencer for the ping-pong Game-of-Life row banks: primes the line buffer,
// walks the grid with toroidal wrap, shares the current-bank read port with the display.
module life_gen_scheduler #(
    parameter int Y_SIZE  = 720,
    parameter int Y_WIDTH = $clog2(Y_SIZE)
) (
    input  logic               out_stream_aclk,
    input  logic               periph_resetn,
    input  logic               init_done,
    input  logic               pause,
    input  logic               step,
    input  logic               frame_sof,
    input  logic               disp_req,
    input  logic [Y_WIDTH-1:0] disp_addr,
    output logic               rd_en,
    output logic [Y_WIDTH-1:0] rd_addr,
    output logic [2:0]         lb_load,
    output logic               lb_shift,
    output logic               wr_en,
    output logic [Y_WIDTH-1:0] wr_addr,
    output logic               bank_sel,
    output logic               busy,
    output logic               gen_done,
    output logic [31:0]        gen_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_CALC,
        S_ISSUE,
        S_LOAD,
        S_SWAP_WAIT
    } state_t;

    localparam logic [Y_WIDTH-1:0] ROW_LAST = Y_WIDTH'(Y_SIZE - 1);
    localparam logic [2:0]         LD_TOP   = 3'b001;
    localparam logic [2:0]         LD_MID   = 3'b010;
    localparam logic [2:0]         LD_BOT   = 3'b100;

    state_t             state_q, state_d;
    logic [Y_WIDTH-1:0] row_q, row_d;
    logic [1:0]         prime_cnt_q, prime_cnt_d;
    logic [2:0]         lb_load_q, lb_load_d;
    logic               gen_done_q, gen_done_d;
    logic               bank_sel_q, bank_sel_d;
    logic [31:0]        gen_count_q, gen_count_d;

    logic               sched_want;
    logic               sched_issue;
    logic [Y_WIDTH-1:0] sched_addr;
    logic               disp_grant;

    function automatic logic [Y_WIDTH-1:0] row_inc(input logic [Y_WIDTH-1:0] r);
        return (r == ROW_LAST) ? '0 : r + Y_WIDTH'(1);
    endfunction

    // Scheduler read request; in ISSUE row_q already points at the row being computed next.
    always_comb begin
        sched_want = 1'b0;
        sched_addr = '0;
        case (state_q)
            S_PRIME: begin
                sched_want = 1'b1;
                case (prime_cnt_q)
                    2'd0:    sched_addr = ROW_LAST;
                    2'd1:    sched_addr = '0;
                    default: sched_addr = Y_WIDTH'(1);
                endcase
            end
            S_ISSUE: begin
                sched_want = 1'b1;
                sched_addr = row_inc(row_q);
            end
            default: ;
        endcase
    end

    assign disp_grant  = periph_resetn & disp_req;
    assign sched_issue = sched_want & ~disp_req;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        prime_cnt_d = prime_cnt_q;
        lb_load_d   = 3'b000;
        gen_done_d  = 1'b0;
        bank_sel_d  = bank_sel_q;
        gen_count_d = gen_count_q;
        case (state_q)
            S_IDLE: begin
                if (init_done && (!pause || step)) begin
                    state_d     = S_PRIME;
                    row_d       = '0;
                    prime_cnt_d = 2'd0;
                end
            end
            S_PRIME: begin
                if (sched_issue) begin
                    case (prime_cnt_q)
                        2'd0: begin
                            lb_load_d   = LD_TOP;
                            prime_cnt_d = 2'd1;
                        end
                        2'd1: begin
                            lb_load_d   = LD_MID;
                            prime_cnt_d = 2'd2;
                        end
                        default: begin
                            lb_load_d = LD_BOT;
                            state_d   = S_LOAD;
                        end
                    endcase
                end
            end
            S_CALC: begin
                if (row_q == ROW_LAST) begin
                    state_d    = S_SWAP_WAIT;
                    gen_done_d = 1'b1;
                end else begin
                    row_d   = row_inc(row_q);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (sched_issue) begin
                    lb_load_d = LD_BOT;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: state_d = S_CALC;
            S_SWAP_WAIT: begin
                // The gen_done cycle itself never swaps, so a coincident sof is skipped.
                if (frame_sof && !gen_done_q) begin
                    bank_sel_d  = ~bank_sel_q;
                    gen_count_d = gen_count_q + 32'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            prime_cnt_q <= 2'd0;
            lb_load_q   <= 3'b000;
            gen_done_q  <= 1'b0;
            bank_sel_q  <= 1'b0;
            gen_count_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            prime_cnt_q <= prime_cnt_d;
            lb_load_q   <= lb_load_d;
            gen_done_q  <= gen_done_d;
            bank_sel_q  <= bank_sel_d;
            gen_count_q <= gen_count_d;
        end
    end

    assign rd_en     = disp_grant | sched_issue;
    assign rd_addr   = disp_grant ? disp_addr : (sched_issue ? sched_addr : '0);
    assign lb_load   = lb_load_q;
    assign wr_en     = (state_q == S_CALC);
    assign wr_addr   = wr_en ? row_q : '0;
    // The row-719 write ends the generation; the buffer is not advanced past it.
    assign lb_shift  = wr_en && (row_q != ROW_LAST);
    assign bank_sel  = bank_sel_q;
    assign busy      = (state_q != S_IDLE);
    assign gen_done  = gen_done_q;
    assign gen_count = gen_count_q;

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Scoreboard bench for life_gen_scheduler: expected read/write streams are queued per generation
// and consumed by a monitor; scenario tasks check timing, arbitration, swap and reset behaviour.
module tb_life_gen_scheduler;

    localparam int Y_SIZE  = 720;
    localparam int Y_WIDTH = 10;
    localparam int NO_BLK  = 1 << 30;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               init_done = 1'b0;
    logic               pause = 1'b1;
    logic               step = 1'b0;
    logic               frame_sof = 1'b0;
    logic               disp_req = 1'b0;
    logic [Y_WIDTH-1:0] disp_addr = '0;
    logic               rd_en;
    logic [Y_WIDTH-1:0] rd_addr;
    logic [2:0]         lb_load;
    logic               lb_shift;
    logic               wr_en;
    logic [Y_WIDTH-1:0] wr_addr;
    logic               bank_sel;
    logic               busy;
    logic               gen_done;
    logic [31:0]        gen_count;

    life_gen_scheduler #(.Y_SIZE(Y_SIZE), .Y_WIDTH(Y_WIDTH)) dut (
        .out_stream_aclk(clk),
        .periph_resetn  (rst_n),
        .init_done      (init_done),
        .pause          (pause),
        .step           (step),
        .frame_sof      (frame_sof),
        .disp_req       (disp_req),
        .disp_addr      (disp_addr),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .lb_load        (lb_load),
        .lb_shift       (lb_shift),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .bank_sel       (bank_sel),
        .busy           (busy),
        .gen_done       (gen_done),
        .gen_count      (gen_count)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [Y_WIDTH-1:0] addr;
        int                 cyc;
        logic [2:0]         load;
    } rd_exp_t;

    typedef struct {
        logic [Y_WIDTH-1:0] addr;
        int                 cyc;
        logic               shift;
    } wr_exp_t;

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];
    bit      mon_en = 1'b0;

    // One generation's expected reads and writes; cycles at or after bs slip by bl.
    task automatic push_gen(input int base, input int bs, input int bl);
        rd_exp_t r;
        wr_exp_t w;
        int      c;
        for (int k = 0; k < 3; k++) begin
            r.addr = (k == 0) ? 10'd719 : 10'(k - 1);
            r.load = (k == 0) ? 3'b001 : ((k == 1) ? 3'b010 : 3'b100);
            c = k;
            r.cyc = base + c + ((c >= bs) ? bl : 0);
            rd_q.push_back(r);
        end
        for (int k = 0; k < Y_SIZE - 1; k++) begin
            r.addr = 10'((k + 2) % Y_SIZE);
            r.load = 3'b100;
            c = 5 + 3 * k;
            r.cyc = base + c + ((c >= bs) ? bl : 0);
            rd_q.push_back(r);
        end
        for (int k = 0; k < Y_SIZE; k++) begin
            w.addr  = 10'(k);
            w.shift = (k != Y_SIZE - 1);
            c = 4 + 3 * k;
            w.cyc = base + c + ((c >= bs) ? bl : 0);
            wr_q.push_back(w);
        end
    endtask

    // Monitor: consumes scheduler reads and row writes as the DUT produces them.
    initial begin
        rd_exp_t    e;
        wr_exp_t    f;
        logic [2:0] load_exp;
        logic [2:0] load_nxt;
        load_exp = 3'b000;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n || !mon_en) begin
                load_exp = 3'b000;
            end else begin
                load_nxt = 3'b000;
                n_checks++;
                if (lb_load !== load_exp) begin
                    n_fail++;
                    $display("FAIL lb_load: cycle %0d got %b, required %b", cyc_cnt, lb_load, load_exp);
                end
                if (disp_req) begin
                    n_checks++;
                    if (rd_en !== 1'b1 || rd_addr !== disp_addr) begin
                        n_fail++;
                        $display("FAIL disp_pass: cycle %0d got rd_en=%b addr=%0d, required 1/%0d",
                                 cyc_cnt, rd_en, rd_addr, disp_addr);
                    end
                end else if (rd_en) begin
                    n_checks++;
                    if (rd_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_rd: cycle %0d got read of %0d, required none", cyc_cnt, rd_addr);
                    end else begin
                        e = rd_q.pop_front();
                        load_nxt = e.load;
                        if (rd_addr !== e.addr || cyc_cnt !== e.cyc) begin
                            n_fail++;
                            $display("FAIL rd_seq: got addr %0d at cycle %0d, required %0d at cycle %0d",
                                     rd_addr, cyc_cnt, e.addr, e.cyc);
                        end
                    end
                end
                load_exp = load_nxt;
                n_checks++;
                if (wr_en) begin
                    if (wr_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_wr: cycle %0d got write of %0d, required none", cyc_cnt, wr_addr);
                    end else begin
                        f = wr_q.pop_front();
                        if (wr_addr !== f.addr || cyc_cnt !== f.cyc || lb_shift !== f.shift) begin
                            n_fail++;
                            $display("FAIL wr_seq: got addr %0d cyc %0d shift %b, required %0d cyc %0d shift %b",
                                     wr_addr, cyc_cnt, lb_shift, f.addr, f.cyc, f.shift);
                        end
                    end
                end else if (lb_shift !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lb_shift_idle: cycle %0d got %b, required 0", cyc_cnt, lb_shift);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            init_done = 1'($urandom);
            pause     = 1'($urandom);
            step      = 1'($urandom);
            frame_sof = 1'($urandom);
            disp_req  = 1'($urandom);
            disp_addr = 10'($urandom_range(0, Y_SIZE - 1));
            #1;
            n_checks++;
            if ({rd_en, rd_addr, lb_load, lb_shift, wr_en, wr_addr, bank_sel, busy, gen_done, gen_count} !== '0) begin
                n_fail++;
                $display("FAIL reset_outs: rd_en=%b rd_addr=%0d busy=%b gen_count=%0d, required all 0",
                         rd_en, rd_addr, busy, gen_count);
            end
        end
        @(negedge clk);
        init_done = 1'b0; pause = 1'b1; step = 1'b0; frame_sof = 1'b0; disp_req = 1'b0; disp_addr = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_gates();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            init_done = (i >= 45);
            pause     = (i >= 30);
            step      = (i == 35);
            #1;
            n_checks++;
            if (busy !== 1'b0 || rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_gate: phase %0d got busy=%b rd_en=%b, required 0/0", i, busy, rd_en);
            end
        end
    endtask

    task automatic test_single_step();
        int done_t;
        int t;
        @(negedge clk);
        init_done = 1'b1; pause = 1'b1; step = 1'b1; mon_en = 1'b1;
        push_gen(cyc_cnt + 1, NO_BLK, 0);
        @(negedge clk);
        done_t = -1;
        for (t = 0; t < 3000; t++) begin
            step      = (t == 1000);
            frame_sof = (t == 2162);
            #1;
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_gen: cycle %0d got busy=%b, required 1", t, busy);
            end
            if (gen_done === 1'b1) begin
                done_t = t;
                break;
            end
            @(negedge clk);
        end
        step = 1'b0;
        n_checks++;
        if (done_t !== 2162) begin
            n_fail++;
            $display("FAIL gen_done_step: got cycle %0d, required 2162", done_t);
        end
        n_checks++;
        if (rd_q.size() != 0 || wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_ops: got %0d reads %0d writes outstanding, required 0/0", rd_q.size(), wr_q.size());
        end
    endtask

    task automatic test_swap();
        @(negedge clk);
        frame_sof = 1'b0;
        #1;
        n_checks++;
        if (gen_done !== 1'b0 || busy !== 1'b1 || bank_sel !== 1'b0 || gen_count !== 32'd0) begin
            n_fail++;
            $display("FAIL sof_at_done: got gen_done=%b busy=%b bank_sel=%b count=%0d, required 0/1/0/0",
                     gen_done, busy, bank_sel, gen_count);
        end
        for (int i = 2; i < 100; i++) begin
            @(negedge clk);
            step = (i == 50);
            #1;
            n_checks++;
            if (busy !== 1'b1 || bank_sel !== 1'b0) begin
                n_fail++;
                $display("FAIL swap_wait: +%0d got busy=%b bank_sel=%b, required 1/0", i, busy, bank_sel);
            end
        end
        @(negedge clk);
        step = 1'b0; frame_sof = 1'b1;
        #1;
        n_checks++;
        if (bank_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL swap_early: got bank_sel=%b, required 0", bank_sel);
        end
        @(negedge clk);
        frame_sof = 1'b0;
        #1;
        n_checks++;
        if (bank_sel !== 1'b1 || gen_count !== 32'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL swap: got bank_sel=%b count=%0d busy=%b, required 1/1/0", bank_sel, gen_count, busy);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (busy !== 1'b0 || rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL stay_idle: got busy=%b rd_en=%b, required 0/0", busy, rd_en);
            end
        end
    endtask

    task automatic test_contention();
        int done_t;
        int t;
        @(negedge clk);
        step = 1'b1;
        push_gen(cyc_cnt + 1, 35, 10);
        @(negedge clk);
        step = 1'b0;
        done_t = -1;
        for (t = 0; t < 3000; t++) begin
            disp_req  = (t >= 35 && t < 45);
            disp_addr = disp_req ? 10'd37 : 10'd0;
            #1;
            if (disp_req) begin
                n_checks++;
                if (rd_addr !== 10'd37 || lb_load !== 3'b000) begin
                    n_fail++;
                    $display("FAIL contention: cycle %0d got rd_addr=%0d lb_load=%b, required 37/000", t, rd_addr, lb_load);
                end
            end
            if (gen_done === 1'b1) begin
                done_t = t;
                break;
            end
            @(negedge clk);
        end
        disp_req = 1'b0; disp_addr = '0;
        n_checks++;
        if (done_t !== 2172) begin
            n_fail++;
            $display("FAIL gen_done_contention: got cycle %0d, required 2172", done_t);
        end
        @(negedge clk);
        frame_sof = 1'b1;
        @(negedge clk);
        frame_sof = 1'b0;
        #1;
        n_checks++;
        if (bank_sel !== 1'b0 || gen_count !== 32'd2 || busy !== 1'b0 || rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL swap2: got bank_sel=%b count=%0d busy=%b left=%0d, required 0/2/0/0",
                     bank_sel, gen_count, busy, rd_q.size());
        end
    endtask

    task automatic test_pause_mid();
        int done_t;
        int t;
        @(negedge clk);
        pause = 1'b0;
        push_gen(cyc_cnt + 1, NO_BLK, 0);
        @(negedge clk);
        done_t = -1;
        for (t = 0; t < 3000; t++) begin
            if (t == 904) pause = 1'b1;
            #1;
            if (gen_done === 1'b1) begin
                done_t = t;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (done_t !== 2162) begin
            n_fail++;
            $display("FAIL gen_done_pause: got cycle %0d, required 2162", done_t);
        end
        @(negedge clk);
        frame_sof = 1'b1;
        @(negedge clk);
        frame_sof = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            n_checks++;
            if (busy !== 1'b0 || rd_en !== 1'b0 || gen_count !== 32'd3 || bank_sel !== 1'b1) begin
                n_fail++;
                $display("FAIL pause_stop: got busy=%b rd_en=%b count=%0d bank_sel=%b, required 0/0/3/1",
                         busy, rd_en, gen_count, bank_sel);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        int done_t;
        int t;
        pause = 1'b0;
        push_gen(cyc_cnt + 1, NO_BLK, 0);
        @(negedge clk);
        for (t = 0; t < 904; t++) @(negedge clk);
        #1;
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 10'd300) begin
            n_fail++;
            $display("FAIL row300: got wr_en=%b wr_addr=%0d, required 1/300", wr_en, wr_addr);
        end
        #2;
        rst_n = 1'b0;
        mon_en = 1'b0;
        rd_q.delete();
        wr_q.delete();
        #1;
        n_checks++;
        if ({rd_en, lb_load, lb_shift, wr_en, wr_addr, bank_sel, busy, gen_done, gen_count} !== '0) begin
            n_fail++;
            $display("FAIL async_clear: got wr_en=%b busy=%b bank_sel=%b count=%0d, required all 0",
                     wr_en, busy, bank_sel, gen_count);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        push_gen(cyc_cnt + 1, NO_BLK, 0);
        @(negedge clk);
        pause = 1'b1;
        done_t = -1;
        for (t = 0; t < 3000; t++) begin
            #1;
            if (gen_done === 1'b1) begin
                done_t = t;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (done_t !== 2162 || bank_sel !== 1'b0 || gen_count !== 32'd0 || rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL restart: got done=%0d bank_sel=%b count=%0d left=%0d, required 2162/0/0/0",
                     done_t, bank_sel, gen_count, rd_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_idle_gates();
        test_single_step();
        test_swap();
        test_contention();
        test_pause_mid();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
